// File: rtl/aui_pkg.sv
// Shared constants and types for the AM insertion scheduler.
package aui_pkg;
  localparam int BITS_BLOCK    = 257;
  localparam int AM_BLOCKS     = 4;
  localparam int DATA_BLOCKS   = 36;
  localparam int MAX_BLOCKS_AM = AM_BLOCKS + DATA_BLOCKS;
  localparam int AM_WORD_W     = AM_BLOCKS * BITS_BLOCK;
  localparam int PCNT_W        = 16;
  localparam int IDX_W         = 6;
  localparam int AM_SEL_W      = 2;
  localparam int NUM_LANES     = 2;

  typedef logic [BITS_BLOCK-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AM,
    ST_DATA
  } am_sched_state_t;
endpackage

// File: rtl/am_block_slicer.sv
// Selects AM block k out of one flow's mapped AM word.
module am_block_slicer
  import aui_pkg::*;
(
  input  logic [AM_WORD_W-1:0] am_word,
  input  logic [AM_SEL_W-1:0]  sel,
  output block_t               blk
);

  // block k lives at [k*BITS_BLOCK +: BITS_BLOCK]
  always_comb begin
    blk = am_word[sel*BITS_BLOCK +: BITS_BLOCK];
  end

endmodule

// File: rtl/am_insert_scheduler.sv
// Interleaves AM blocks and payload blocks for two lockstep flows into a
// registered output stage with valid/ready flow control.
module am_insert_scheduler
  import aui_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [AM_WORD_W-1:0]  i_am_f0,
  input  logic [AM_WORD_W-1:0]  i_am_f1,
  input  logic [BITS_BLOCK-1:0] i_data_f0,
  input  logic [BITS_BLOCK-1:0] i_data_f1,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [BITS_BLOCK-1:0] o_flow_0,
  output logic [BITS_BLOCK-1:0] o_flow_1,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic                  o_is_am,
  output logic [IDX_W-1:0]      o_block_idx,
  output logic [PCNT_W-1:0]     o_period_cnt,
  output logic                  o_am_start
);

  am_sched_state_t                        state;
  logic [IDX_W-1:0]                       pos;      // position of the next block to load
  logic [NUM_LANES-1:0][AM_WORD_W-1:0]    am_in;
  logic [NUM_LANES-1:0][AM_WORD_W-1:0]    snap;
  logic [NUM_LANES-1:0][AM_WORD_W-1:0]    am_src;
  logic [NUM_LANES-1:0][BITS_BLOCK-1:0]   am_blk;
  logic [NUM_LANES-1:0][BITS_BLOCK-1:0]   data_in;
  logic [NUM_LANES-1:0][BITS_BLOCK-1:0]   flow_q;
  logic                                   load_en;
  logic                                   last_am;
  logic                                   last_blk;

  assign am_in    = {i_am_f1, i_am_f0};
  assign data_in  = {i_data_f1, i_data_f0};
  assign o_flow_0 = flow_q[0];
  assign o_flow_1 = flow_q[1];

  assign load_en      = !o_valid | i_out_ready;
  assign o_data_ready = (state == ST_DATA) & load_en;
  assign last_am      = (pos == IDX_W'(AM_BLOCKS - 1));
  assign last_blk     = (pos == IDX_W'(MAX_BLOCKS_AM - 1));

  // block 0 comes straight from the live AM word (snapshot is taken in the
  // same cycle); later blocks of the period come from the frozen snapshot
  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign am_src[l] = (pos == '0) ? am_in[l] : snap[l];
      am_block_slicer u_slicer (
        .am_word (am_src[l]),
        .sel     (pos[AM_SEL_W-1:0]),
        .blk     (am_blk[l])
      );
    end
  endgenerate

  // scheduler FSM, position/period counters and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pos          <= '0;
      snap         <= '0;
      flow_q       <= '0;
      o_valid      <= 1'b0;
      o_is_am      <= 1'b0;
      o_block_idx  <= '0;
      o_period_cnt <= '0;
      o_am_start   <= 1'b0;
    end else begin
      o_am_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en) o_valid <= 1'b0;
          if (i_enable) state <= ST_AM;
        end
        ST_AM: begin
          if (load_en) begin
            flow_q      <= am_blk;
            o_valid     <= 1'b1;
            o_is_am     <= 1'b1;
            o_block_idx <= pos;
            pos         <= pos + 1'b1;
            if (pos == '0) begin
              snap       <= am_in;
              o_am_start <= 1'b1;
            end
            if (last_am) state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (load_en) begin
            if (i_data_valid) begin
              flow_q      <= data_in;
              o_valid     <= 1'b1;
              o_is_am     <= 1'b0;
              o_block_idx <= pos;
              if (last_blk) begin
                pos          <= '0;
                o_period_cnt <= o_period_cnt + 1'b1;
                state        <= i_enable ? ST_AM : ST_IDLE;
              end else begin
                pos <= pos + 1'b1;
              end
            end else begin
              // bubble: nothing to send, index stays on the last block sent
              o_valid <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am_insert_scheduler.sv
// Directed bench for am_insert_scheduler: period sequencing, backpressure,
// payload bubbles, AM snapshotting, enable drop and mid-run reset.
module tb_am_insert_scheduler;
  import aui_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_enable;
  logic [AM_WORD_W-1:0]  i_am_f0, i_am_f1;
  logic [BITS_BLOCK-1:0] i_data_f0, i_data_f1;
  logic                  i_data_valid;
  logic                  o_data_ready;
  logic [BITS_BLOCK-1:0] o_flow_0, o_flow_1;
  logic                  o_valid;
  logic                  i_out_ready;
  logic                  o_is_am;
  logic [IDX_W-1:0]      o_block_idx;
  logic [PCNT_W-1:0]     o_period_cnt;
  logic                  o_am_start;

  int ncmp = 0;
  int nerr = 0;

  logic [AM_WORD_W-1:0] w_ones, w_zero, w_f1;

  am_insert_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_am_f0      (i_am_f0),
    .i_am_f1      (i_am_f1),
    .i_data_f0    (i_data_f0),
    .i_data_f1    (i_data_f1),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_flow_0     (o_flow_0),
    .o_flow_1     (o_flow_1),
    .o_valid      (o_valid),
    .i_out_ready  (i_out_ready),
    .o_is_am      (o_is_am),
    .o_block_idx  (o_block_idx),
    .o_period_cnt (o_period_cnt),
    .o_am_start   (o_am_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BITS_BLOCK-1:0] obs,
                     input logic [BITS_BLOCK-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive payload for position idx, clock once, expect block idx at the output
  task automatic adv(input int idx, input logic [AM_WORD_W-1:0] w0,
                     input logic [AM_WORD_W-1:0] w1);
    i_data_f0 = BITS_BLOCK'(1000 + idx);
    i_data_f1 = BITS_BLOCK'(2000 + idx);
    tick();
    chk($sformatf("idx@%0d", idx), BITS_BLOCK'(o_block_idx), BITS_BLOCK'(idx));
    chk($sformatf("valid@%0d", idx), BITS_BLOCK'(o_valid), BITS_BLOCK'(1));
    chk($sformatf("is_am@%0d", idx), BITS_BLOCK'(o_is_am), BITS_BLOCK'(idx < AM_BLOCKS));
    chk($sformatf("am_start@%0d", idx), BITS_BLOCK'(o_am_start), BITS_BLOCK'(idx == 0));
    if (idx < AM_BLOCKS) begin
      chk($sformatf("am_f0@%0d", idx), o_flow_0, w0[idx*BITS_BLOCK +: BITS_BLOCK]);
      chk($sformatf("am_f1@%0d", idx), o_flow_1, w1[idx*BITS_BLOCK +: BITS_BLOCK]);
    end else begin
      chk($sformatf("data_f0@%0d", idx), o_flow_0, BITS_BLOCK'(1000 + idx));
      chk($sformatf("data_f1@%0d", idx), o_flow_1, BITS_BLOCK'(2000 + idx));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_f0"},    o_flow_0, '0);
    chk({tag, "_f1"},    o_flow_1, '0);
    chk({tag, "_valid"}, BITS_BLOCK'(o_valid), '0);
    chk({tag, "_is_am"}, BITS_BLOCK'(o_is_am), '0);
    chk({tag, "_idx"},   BITS_BLOCK'(o_block_idx), '0);
    chk({tag, "_pcnt"},  BITS_BLOCK'(o_period_cnt), '0);
    chk({tag, "_start"}, BITS_BLOCK'(o_am_start), '0);
    chk({tag, "_ready"}, BITS_BLOCK'(o_data_ready), '0);
  endtask

  initial begin
    w_ones = '1;
    w_zero = '0;
    for (int k = 0; k < AM_BLOCKS; k++)
      w_f1[k*BITS_BLOCK +: BITS_BLOCK] = {1'b1, 256'(k * 3 + 7)};

    rst = 1'b1; i_enable = 1'b0; i_am_f0 = w_ones; i_am_f1 = w_f1;
    i_data_f0 = '0; i_data_f1 = '0; i_data_valid = 1'b1; i_out_ready = 1'b1;
    tick(); tick();
    chk_reset("rst");

    // period 1: IDLE sees enable, block 0 loads on the following edge
    rst = 1'b0; i_enable = 1'b1;
    tick();
    chk("lat_valid", BITS_BLOCK'(o_valid), '0);
    adv(0, w_ones, w_f1);
    i_am_f0 = w_zero;                 // ignored until next period
    adv(1, w_ones, w_f1);
    adv(2, w_ones, w_f1);

    // backpressure at idx 2
    i_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_idx",   BITS_BLOCK'(o_block_idx), BITS_BLOCK'(2));
      chk("hold_valid", BITS_BLOCK'(o_valid), BITS_BLOCK'(1));
      chk("hold_f0",    o_flow_0, w_ones[2*BITS_BLOCK +: BITS_BLOCK]);
      chk("hold_f1",    o_flow_1, w_f1[2*BITS_BLOCK +: BITS_BLOCK]);
      chk("hold_ready", BITS_BLOCK'(o_data_ready), '0);
    end
    i_out_ready = 1'b1;
    adv(3, w_ones, w_f1);
    chk("ready_data", BITS_BLOCK'(o_data_ready), BITS_BLOCK'(1));
    for (int i = 4; i <= 10; i++) adv(i, w_ones, w_f1);

    // payload bubble at idx 10
    i_data_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bub_valid", BITS_BLOCK'(o_valid), '0);
      chk("bub_idx",   BITS_BLOCK'(o_block_idx), BITS_BLOCK'(10));
    end
    i_data_valid = 1'b1;
    for (int i = 11; i < MAX_BLOCKS_AM; i++) adv(i, w_ones, w_f1);
    chk("pcnt1", BITS_BLOCK'(o_period_cnt), BITS_BLOCK'(1));

    // period 2 picks up the live (now zero) AM word; enable drops at idx 20
    for (int i = 0; i <= 20; i++) adv(i, w_zero, w_f1);
    i_enable = 1'b0;
    for (int i = 21; i < MAX_BLOCKS_AM; i++) adv(i, w_zero, w_f1);
    chk("pcnt2", BITS_BLOCK'(o_period_cnt), BITS_BLOCK'(2));
    tick();
    chk("idle_valid", BITS_BLOCK'(o_valid), '0);
    chk("idle_ready", BITS_BLOCK'(o_data_ready), '0);
    tick();
    chk("idle_valid2", BITS_BLOCK'(o_valid), '0);
    chk("idle_idx",    BITS_BLOCK'(o_block_idx), BITS_BLOCK'(39));
    chk("idle_pcnt",   BITS_BLOCK'(o_period_cnt), BITS_BLOCK'(2));

    // period 3, then reset at idx 25
    i_am_f0 = w_ones; i_enable = 1'b1;
    tick();
    chk("p3_lat", BITS_BLOCK'(o_valid), '0);
    for (int i = 0; i <= 25; i++) adv(i, w_ones, w_f1);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    tick();
    chk("post_lat", BITS_BLOCK'(o_valid), '0);
    adv(0, w_ones, w_f1);
    chk("post_pcnt", BITS_BLOCK'(o_period_cnt), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
